fifo_read_ctrl: RTL and testbench

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

---
 rtl/fifo_read_ctrl.sv | 73 +++++++
 tb/tb_fifo_read_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for an asynchronous FIFO.
// Tracks the read pointer, derives occupancy and flags from the synced write pointer.
module fifo_read_ctrl #(
    parameter int PTR_WIDTH = 8,
    parameter int AE_THRESH = 4
) (
    input  logic                   r_clk_i,
    input  logic                   r_rst_i,
    input  logic                   r_en_i,
    input  logic [0:PTR_WIDTH-1]   r_w_ptr_i,
    output logic [PTR_WIDTH-2:0]   r_addr_o,
    output logic [0:PTR_WIDTH-1]   r_ptr_o,
    output logic                   r_empty_o,
    output logic                   r_almost_empty_o,
    output logic [PTR_WIDTH-1:0]   r_count_o,
    output logic                   r_underflow_o
);

    localparam logic [PTR_WIDTH-1:0] AE_T = PTR_WIDTH'(AE_THRESH);
    localparam logic [PTR_WIDTH-1:0] ONE  = PTR_WIDTH'(1);

    logic [PTR_WIDTH-1:0] r_bin;
    logic [PTR_WIDTH-1:0] r_bin_next;
    logic [PTR_WIDTH-1:0] r_gray_next;
    logic [PTR_WIDTH-1:0] w_gray;
    logic [PTR_WIDTH-1:0] w_bin;
    logic [PTR_WIDTH-1:0] count_next;
    logic                 pop;

    // The head of the FIFO is the low bits of the binary read pointer.
    assign r_addr_o = r_bin[PTR_WIDTH-2:0];

    // Incoming Gray pointer viewed as a plain MSB-first number.
    assign w_gray = r_w_ptr_i;

    // Gray to binary: each bit is the XOR of itself and all bits above it.
    always_comb begin
        w_bin = '0;
        for (int i = 0; i < PTR_WIDTH; i++) begin
            w_bin[i] = ^(w_gray >> i);
        end
    end

    // Next read pointer; a pop is honoured only when the FIFO is not empty.
    always_comb begin
        pop         = r_en_i & ~r_empty_o;
        r_bin_next  = pop ? (r_bin + ONE) : r_bin;
        r_gray_next = r_bin_next ^ (r_bin_next >> 1);
        count_next  = w_bin - r_bin_next;
    end

    // Register pointer, flags and occupancy; underflow is sticky until reset.
    always_ff @(posedge r_clk_i) begin
        if (r_rst_i) begin
            r_bin            <= '0;
            r_ptr_o          <= '0;
            r_empty_o        <= 1'b1;
            r_almost_empty_o <= 1'b1;
            r_count_o        <= '0;
            r_underflow_o    <= 1'b0;
        end else begin
            r_bin            <= r_bin_next;
            r_ptr_o          <= r_gray_next;
            r_empty_o        <= (r_gray_next == w_gray);
            r_almost_empty_o <= (count_next <= AE_T);
            r_count_o        <= count_next;
            if (r_en_i && r_empty_o) begin
                r_underflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl.
// A counting model (entries written vs. entries read) predicts every output.
module tb_fifo_read_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [0:7] wptr = '0;
    logic [6:0] addr;
    logic [0:7] rptr;
    logic       empty;
    logic       aempty;
    logic [7:0] count;
    logic       uflow;

    int unsigned wr_total = 0;
    int unsigned rd_total = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          m_empty = 1'b1;
    bit          m_uflow = 1'b0;

    fifo_read_ctrl #(.PTR_WIDTH(8), .AE_THRESH(4)) dut (
        .r_clk_i          (clk),
        .r_rst_i          (rst),
        .r_en_i           (en),
        .r_w_ptr_i        (wptr),
        .r_addr_o         (addr),
        .r_ptr_o          (rptr),
        .r_empty_o        (empty),
        .r_almost_empty_o (aempty),
        .r_count_o        (count),
        .r_underflow_o    (uflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gray8(input int unsigned x);
        logic [7:0] b;
        b = x[7:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, check all outputs.
    task automatic step(input bit pop_req, input bit do_rst);
        int unsigned occ;
        en   = pop_req;
        rst  = do_rst;
        wptr = gray8(wr_total);
        @(posedge clk);
        if (do_rst) begin
            rd_total = 0;
            wr_total = 0;
            m_uflow  = 1'b0;
        end else begin
            if (pop_req && m_empty) m_uflow = 1'b1;
            if (pop_req && !m_empty) rd_total++;
        end
        occ     = do_rst ? 0 : (wr_total - rd_total);
        m_empty = (occ == 0);
        #1;
        chk("count",  {24'd0, count},  occ);
        chk("empty",  {31'd0, empty},  {31'd0, m_empty});
        chk("aempty", {31'd0, aempty}, {31'd0, (occ <= 4)});
        chk("addr",   {25'd0, addr},   rd_total % 128);
        chk("rptr",   {24'd0, rptr},   {24'd0, gray8(rd_total)});
        chk("uflow",  {31'd0, uflow},  {31'd0, m_uflow});
    endtask

    initial begin
        // Reset values.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Underflow: pops against an empty FIFO are ignored, flag sticks.
        repeat (3) step(1'b1, 1'b0);
        chk("uflow_sticky", {31'd0, uflow}, 32'd1);

        // Five entries, then drain.
        step(1'b0, 1'b1);
        wr_total = 5;
        step(1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b0);
        chk("ptr_after5", {24'd0, rptr}, 32'h07);
        chk("empty_after5", {31'd0, empty}, 32'd1);

        // Full: 128 entries outstanding.
        step(1'b0, 1'b1);
        wr_total = 128;
        step(1'b0, 1'b0);
        chk("full_count", {24'd0, count}, 32'd128);

        // Walk the read pointer to 254 with simultaneous push/pop at count 1.
        step(1'b0, 1'b1);
        wr_total = 1;
        step(1'b0, 1'b0);
        while (rd_total < 254) begin
            wr_total++;
            step(1'b1, 1'b0);
        end
        chk("simul_count", {24'd0, count}, 32'd1);
        // Wrap: writer at 258 (Gray(2) on the 8-bit bus), drain four.
        wr_total = 258;
        step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);
        chk("wrap_addr", {25'd0, addr}, 32'd2);
        chk("wrap_empty", {31'd0, empty}, 32'd1);

        // Randomized traffic; the writer never overfills.
        step(1'b0, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            if ((wr_total - rd_total) < 128 && $urandom_range(0, 2) != 0)
                wr_total += $urandom_range(1, 2);
            if ((wr_total - rd_total) > 128) wr_total = rd_total + 128;
            step(1'($urandom_range(0, 1)), 1'b0);
        end

        // Reset mid-operation with a pop pending.
        step(1'b0, 1'b1);
        wr_total = 10;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("rst_mid_count", {24'd0, count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
